muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/register width in bits.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request an operation this cycle.
REQ-005 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; all other codes invalid.
REQ-006 opA  input  WIDTH  first operand, driven from the register file's ReadDataA.
REQ-007 opB  input  WIDTH  second operand, driven from the register file's ReadDataB.
REQ-008 busy  output  1  unit is occupied; new start requests are ignored while high.
REQ-009 done  output  1  one-cycle pulse; hi/lo hold a new mul/div result.
REQ-010 hi  output  WIDTH  HI register, registered output.
REQ-011 lo  output  WIDTH  LO register, registered output.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; busy=1 in RUN and DONE.
REQ-013 In IDLE, start=1 with MULT/MULTU/DIV/DIVU SHALL latch opA, opB and op, load the iteration counter with WIDTH and enter RUN.
REQ-014 RUN SHALL process one bit per cycle (shift-add multiply, restoring divide) and decrement the counter; at counter 0 it SHALL enter DONE.
REQ-015 DONE SHALL load hi/lo on entry, assert done for exactly one cycle, then return to IDLE.
REQ-016 Latency: done high in the cycle beginning WIDTH+1 edges after the start-accepting edge; WIDTH=32 gives 33.
REQ-017 start in RUN or DONE SHALL be ignored with no queuing; the latched operands SHALL be unaffected.
REQ-018 MTHI/MTLO in IDLE SHALL write opA to hi/lo at the next edge, take one cycle, and assert neither busy nor done.
REQ-019 Invalid op codes with start=1 SHALL be ignored.
REQ-020 hi/lo SHALL keep their previous values throughout RUN and change only at DONE entry or on MTHI/MTLO.
REQ-021 Multiply: full 2*WIDTH-bit product; hi=upper half, lo=lower half; MULT signed two's complement, MULTU unsigned.
REQ-022 Divide: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend; DIV signed, DIVU unsigned.
REQ-023 Signed operations SHALL run on magnitudes and apply the result sign in DONE.
REQ-024 Divide by zero SHALL take full latency and give lo=all ones and hi=dividend (opA).
REQ-025 DIV of the most negative value by -1 SHALL give lo=most negative value and hi=0.

Reset
REQ-026 reset low SHALL asynchronously force: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, operand registers 0.
REQ-027 reset during RUN/DONE SHALL abort the operation with no partial result visible; after release, the unit SHALL accept start on the first rising edge.

Configuration
REQ-028 Macro MULDIV_DIVIDE_EN defined: divide datapath compiled in, and DIV/DIVU behave per REQ-022..025.
REQ-029 MULDIV_DIVIDE_EN undefined: divide logic absent, and DIV/DIVU are treated as invalid per REQ-019 (no busy, no done, hi/lo unchanged).

Structure
REQ-030 Package muldiv_pkg SHALL hold the op encodings, the FSM state encoding and the default WIDTH constant.
REQ-031 Sub-module muldiv_datapath SHALL hold the iterative shift/add/subtract logic; muldiv_unit SHALL hold the FSM, counter, sign handling and hi/lo registers.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles, done pulse in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo hold their old values until done.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064 after full latency.
REQ-036 MULTU 7x6 with a second start (MTHI 0x55) at cycle 5 -> second start ignored, hi=0, lo=42; reset pulse at cycle 10 of a new MULT -> busy=0, hi=lo=0 immediately.
REQ-037 Build without MULDIV_DIVIDE_EN, DIV 10/2 -> busy stays 0, no done, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the multiply/divide unit.
//   DEFAULT_WIDTH : default operand/register width
//   op_e          : operation codes presented on muldiv_unit.op
//   state_e       : control FSM state encoding
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: iterative unsigned shift-add multiplier / restoring divider.
// Works purely on magnitudes; sign handling lives in muldiv_unit.
// Build option: MULDIV_DIVIDE_EN compiles in the divide step and the isDiv port.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load              capture magA/magB and clear the accumulator
//   step              perform one bit iteration
//   isDiv             iterate as divider instead of multiplier (divide builds only)
//   magA, magB        unsigned operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc, mq           multiply: {acc,mq} = product; divide: acc = remainder, mq = quotient
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
`ifdef MULDIV_DIVIDE_EN
  input  logic             isDiv,
`endif
  input  logic [WIDTH-1:0] magA,
  input  logic [WIDTH-1:0] magB,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mq
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   addSum;

  // Multiply step: conditionally add multiplicand, then shift {sum,mq} right by one.
  assign addSum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);

`ifdef MULDIV_DIVIDE_EN
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] remDiff;

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  // remDiff[WIDTH] set means the subtraction borrowed (restore).
  assign remShift = {acc, mq[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, mcand};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
    end else if (load) begin
      acc   <= '0;
      mq    <= magA;
      mcand <= magB;
    end else if (step) begin
`ifdef MULDIV_DIVIDE_EN
      if (isDiv) begin
        if (!remDiff[WIDTH]) begin
          acc <= remDiff[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc <= remShift[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        acc <= addSum[WIDTH:1];
        mq  <= {addSum[0], mq[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit with an IDLE/RUN/DONE FSM.
// Build option: MULDIV_DIVIDE_EN enables DIV/DIVU; otherwise they are invalid ops.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start        request an operation (ignored while busy)
//   op           operation code (muldiv_pkg::op_e)
//   opA, opB     operands from the register file read ports
//   busy         unit occupied (RUN and DONE)
//   done         one-cycle pulse when hi/lo receive a mul/div result
//   hi, lo       HI/LO result registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e             state;
  logic [CW-1:0]      count;
  logic               negRes;
  logic               opSigned;
  logic               acceptOp;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   hiNext;
  logic [WIDTH-1:0]   loNext;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodRes;
`ifdef MULDIV_DIVIDE_EN
  logic               opIsDiv;
  logic               isDivReg;
  logic               negRem;
  logic               divZero;
`endif

  // Decode the requested op and form operand magnitudes for the datapath.
  always_comb begin
    opSigned = (op == OP_MULT);
    acceptOp = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_DIVIDE_EN
    opIsDiv  = (op == OP_DIV) || (op == OP_DIVU);
    opSigned = opSigned || (op == OP_DIV);
    acceptOp = acceptOp || opIsDiv;
`endif
    magA = (opSigned && opA[WIDTH-1]) ? -opA : opA;
    magB = (opSigned && opB[WIDTH-1]) ? -opB : opB;
  end

  assign load = (state == ST_IDLE) && start && acceptOp;
  assign step = (state == ST_RUN) && (count != '0);

  muldiv_datapath #(.WIDTH(WIDTH)) uDatapath (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
`ifdef MULDIV_DIVIDE_EN
    .isDiv (isDivReg),
`endif
    .magA  (magA),
    .magB  (magB),
    .acc   (acc),
    .mq    (mq)
  );

  // Apply result signs; divide-by-zero forces an all-ones quotient while the
  // remainder path already reproduces the dividend.
  always_comb begin
    prodMag = {acc, mq};
    prodRes = negRes ? -prodMag : prodMag;
    hiNext  = prodRes[2*WIDTH-1:WIDTH];
    loNext  = prodRes[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
    if (isDivReg) begin
      loNext = divZero ? '1 : (negRes ? -mq : mq);
      hiNext = negRem ? -acc : acc;
    end
`endif
  end

  // Control FSM, iteration counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      negRes   <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      isDivReg <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (acceptOp) begin
              state    <= ST_RUN;
              count    <= CW'(WIDTH);
              busy     <= 1'b1;
              negRes   <= opSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
`ifdef MULDIV_DIVIDE_EN
              isDivReg <= opIsDiv;
              negRem   <= opSigned && opA[WIDTH-1];
              divZero  <= (opB == '0);
`endif
            end else if (op == OP_MTHI) begin
              hi <= opA;
            end else if (op == OP_MTLO) begin
              lo <= opA;
            end
          end
        end
        ST_RUN: begin
          if (count == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            hi    <= hiNext;
            lo    <= loNext;
          end else begin
            count <= count - CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model of HI/LO. Honors MULDIV_DIVIDE_EN like the RTL.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           nCmp = 0;
  int           nErr = 0;
  logic [W-1:0] mdlHi = '0;
  logic [W-1:0] mdlLo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 0 = ignored, 1 = single-cycle move, 2 = multi-cycle arithmetic
  function automatic int kindOf(input logic [2:0] o);
    case (o)
      OP_MULT, OP_MULTU: return 2;
`ifdef MULDIV_DIVIDE_EN
      OP_DIV, OP_DIVU:   return 2;
`endif
      OP_MTHI, OP_MTLO:  return 1;
      default:           return 0;
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic refOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        up;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      OP_MULT: begin
        sq = sa * sb;
        mdlHi = sq[63:32];
        mdlLo = sq[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        mdlHi = up[63:32];
        mdlLo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          mdlLo = '1;
          mdlHi = a;
        end else if (o == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          mdlLo = sq[31:0];
          mdlHi = sr[31:0];
        end else begin
          mdlLo = a / b;
          mdlHi = a % b;
        end
      end
      OP_MTHI: mdlHi = a;
      OP_MTLO: mdlLo = a;
      default: ;
    endcase
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int           kind;
    int           doneCyc;
    bit           holdOk;
    bit           busyOk;
    logic [W-1:0] oldHi, oldLo;
    kind  = kindOf(o);
    oldHi = mdlHi;
    oldLo = mdlLo;
    if (kind != 0) refOp(o, a, b);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); opA = $urandom; opB = $urandom;
    if (kind == 2) begin
      check({tag, "_busy_accept"}, 64'(busy), 64'd1);
      doneCyc = 0; holdOk = 1'b1; busyOk = 1'b1;
      for (int c = 1; c <= LAT + 6 && doneCyc == 0; c++) begin
        // A competing request mid-run must be dropped.
        if (c == 5) begin
          start = 1'b1; op = 3'($urandom_range(0, 5)); opA = $urandom; opB = $urandom;
        end
        if (c == 6) start = 1'b0;
        @(posedge clk); #1;
        if (done === 1'b1) doneCyc = c;
        else begin
          if (hi !== oldHi || lo !== oldLo) holdOk = 1'b0;
          if (busy !== 1'b1) busyOk = 1'b0;
        end
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(doneCyc), 64'(LAT));
      check({tag, "_hold"}, 64'(holdOk), 64'd1);
      check({tag, "_busy_run"}, 64'(busyOk), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(mdlHi));
      check({tag, "_lo"}, 64'(lo), 64'(mdlLo));
      @(posedge clk); #1;
      check({tag, "_done_drop"}, 64'(done), 64'd0);
      check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    end else begin
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(mdlHi));
      check({tag, "_lo"}, 64'(lo), 64'(mdlLo));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_k", 64'(lo), 64'h1);

    runOp("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_m3x5_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_m3x5_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFF1);

    runOp("mthi", OP_MTHI, 32'hCAFE_0001, 32'd0);
    runOp("mtlo", OP_MTLO, 32'hBEEF_0002, 32'd0);
    runOp("inv6", 3'd6, 32'h1111_1111, 32'h2222_2222);
    runOp("inv7", 3'd7, 32'h3333_3333, 32'h4444_4444);

`ifdef MULDIV_DIVIDE_EN
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    runOp("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_lo_k", 64'(lo), 64'h8000_0000);
    check("div_min_m1_hi_k", 64'(hi), 64'h0);
    runOp("divu_100_0", OP_DIVU, 32'd100, 32'd0);
    check("divu_100_0_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("divu_100_0_hi_k", 64'(hi), 64'h64);
    runOp("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0);
`else
    runOp("div_off", OP_DIV, 32'd10, 32'd2);
    runOp("divu_off", OP_DIVU, 32'd10, 32'd2);
`endif

    runOp("multu_7x6", OP_MULTU, 32'd7, 32'd6);
    check("multu_7x6_hi_k", 64'(hi), 64'h0);
    check("multu_7x6_lo_k", 64'(lo), 64'd42);

    // Reset mid-operation: immediate clear, then accept on the first edge.
    start = 1'b1; op = OP_MULT; opA = 32'h1234_5678; opB = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    mdlHi = '0;
    mdlLo = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    runOp("post_rst", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);

    for (int i = 0; i < 40; i++) begin
      runOp($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
